nodf_module_status_tracker: RTL and testbench

Cycle-accurate status tracker for one non-dataflow HLS block's ap_start/ap_ready/ap_done/ap_continue handshake in simulation and on-chip debug. It sits beside the monitored block, counts completed transactions, measures per-transaction latency and activity, flags handshake violations, and freezes all statistics when the simulation-level finish signal arrives. The surrounding sampler reads its outputs on the per-transaction and dump strobes.

---
 rtl/nodf_mon_pkg.sv | 15 +
 rtl/nodf_module_status_tracker_if.sv | 47 ++++
 rtl/nodf_sat_counter.sv | 25 ++
 rtl/nodf_module_status_tracker.sv | 137 +++++++++++++
 tb/tb_nodf_module_status_tracker.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/nodf_mon_pkg.sv
// Shared types and constants for the non-dataflow HLS block status tracker.
// Monitor state encoding, default counter width and the min-latency reset value.
package nodf_mon_pkg;

    localparam int DEF_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        FINISHED = 2'd2
    } mon_state_t;

    localparam logic [DEF_CNT_W-1:0] MIN_LAT_RST = '1;

endpackage

// File: rtl/nodf_module_status_tracker_if.sv
// Handshake inputs and status/statistics outputs of the status tracker.
// Optional stall_cycles output exists only when NODF_MON_STALL_CNT_EN is defined.
interface nodf_module_status_tracker_if #(
    parameter int CNT_W = 32
);
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             finish;

    logic [1:0]       mon_state;
    logic [CNT_W-1:0] txn_count;
    logic [CNT_W-1:0] last_latency;
    logic [CNT_W-1:0] min_latency;
    logic [CNT_W-1:0] max_latency;
    logic [CNT_W-1:0] active_cycles;
    logic             sample_vld;
    logic             dump_req;
    logic             incomplete;
    logic             err_spurious_done;
    logic             err_start_drop;
`ifdef NODF_MON_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, finish,
`ifdef NODF_MON_STALL_CNT_EN
        input  stall_cycles,
`endif
        input  mon_state, txn_count, last_latency, min_latency, max_latency,
               active_cycles, sample_vld, dump_req, incomplete,
               err_spurious_done, err_start_drop
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, finish,
`ifdef NODF_MON_STALL_CNT_EN
        output stall_cycles,
`endif
        output mon_state, txn_count, last_latency, min_latency, max_latency,
               active_cycles, sample_vld, dump_req, incomplete,
               err_spurious_done, err_start_drop
    );

endinterface

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter with synchronous clear and freeze; clr together with inc loads 1.
module nodf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!freeze) begin
            if (clr) begin
                count <= inc ? CNT_W'(1) : '0;
            end else if (inc && !(&count)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nodf_module_status_tracker.sv
// Tracks one ap_start/ap_ready/ap_done/ap_continue handshake: counts, latency, activity, errors.
// Optional stall counter is built when NODF_MON_STALL_CNT_EN is defined.
module nodf_module_status_tracker
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                          clock,
    input  logic                          reset,
    nodf_module_status_tracker_if.slave   bus
);

    mon_state_t       state, state_nxt;
    logic             fin_st, done_ev;
    logic             complete, lat_clr, lat_inc, in_flight, start_drop, spurious;
    logic [CNT_W-1:0] lat_cnt, cur_lat, txn_cnt, act_cnt;
    logic [CNT_W-1:0] last_lat, min_lat, max_lat;
    logic             ready_seen, sample_q, dump_q, incomplete_q, esd_q, esp_q;

    assign done_ev = bus.ap_done & bus.ap_continue;
    assign fin_st  = (state == FINISHED);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ap_start && !done_ev) state_nxt = ACTIVE;
            ACTIVE:  if (done_ev && !bus.ap_start) state_nxt = IDLE;
            default: state_nxt = FINISHED;
        endcase
        if (bus.finish) state_nxt = FINISHED;
    end

    // in_flight: a transaction is still open once this cycle's events are applied
    always_comb begin
        complete   = 1'b0;
        lat_clr    = 1'b0;
        lat_inc    = 1'b0;
        in_flight  = 1'b0;
        start_drop = 1'b0;
        spurious   = 1'b0;
        case (state)
            IDLE: begin
                complete  = bus.ap_start & done_ev;
                lat_clr   = bus.ap_start;
                lat_inc   = bus.ap_start;
                in_flight = bus.ap_start & ~done_ev;
                spurious  = bus.ap_done & ~bus.ap_start;
            end
            ACTIVE: begin
                complete   = done_ev;
                lat_clr    = done_ev;
                lat_inc    = 1'b1;
                in_flight  = ~done_ev | bus.ap_start;
                start_drop = ~bus.ap_start & ~ready_seen & ~bus.ap_ready;
            end
            default: ;
        endcase
    end

    assign cur_lat = (state == IDLE) ? CNT_W'(1) :
                     ((&lat_cnt) ? lat_cnt : lat_cnt + 1'b1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_seen   <= 1'b0;
            last_lat     <= '0;
            min_lat      <= '1;
            max_lat      <= '0;
            sample_q     <= 1'b0;
            dump_q       <= 1'b0;
            incomplete_q <= 1'b0;
            esd_q        <= 1'b0;
            esp_q        <= 1'b0;
        end else if (fin_st) begin
            sample_q <= 1'b0;
            dump_q   <= 1'b0;
        end else begin
            sample_q <= complete;
            dump_q   <= bus.finish;
            if (bus.finish && in_flight) incomplete_q <= 1'b1;
            if (spurious)                esd_q        <= 1'b1;
            if (start_drop)              esp_q        <= 1'b1;
            if (lat_clr)                              ready_seen <= bus.ap_ready;
            else if (state == ACTIVE && bus.ap_ready) ready_seen <= 1'b1;
            if (complete) begin
                last_lat <= cur_lat;
                if (cur_lat < min_lat) min_lat <= cur_lat;
                if (cur_lat > max_lat) max_lat <= cur_lat;
            end
        end
    end

    nodf_sat_counter #(.CNT_W(CNT_W)) u_lat_cnt (
        .clock(clock), .reset(reset), .inc(lat_inc), .clr(lat_clr),
        .freeze(fin_st), .count(lat_cnt)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_txn_cnt (
        .clock(clock), .reset(reset), .inc(complete), .clr(1'b0),
        .freeze(fin_st), .count(txn_cnt)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_act_cnt (
        .clock(clock), .reset(reset), .inc(state == ACTIVE), .clr(1'b0),
        .freeze(fin_st), .count(act_cnt)
    );

`ifdef NODF_MON_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    nodf_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock(clock), .reset(reset),
        .inc((state == ACTIVE) & bus.ap_done & ~bus.ap_continue), .clr(1'b0),
        .freeze(fin_st), .count(stall_cnt)
    );

    assign bus.stall_cycles = stall_cnt;
`endif

    assign bus.mon_state         = state;
    assign bus.txn_count         = txn_cnt;
    assign bus.last_latency      = last_lat;
    assign bus.min_latency       = min_lat;
    assign bus.max_latency       = max_lat;
    assign bus.active_cycles     = act_cnt;
    assign bus.sample_vld        = sample_q;
    assign bus.dump_req          = dump_q;
    assign bus.incomplete        = incomplete_q;
    assign bus.err_spurious_done = esd_q;
    assign bus.err_start_drop    = esp_q;

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Directed and random stimulus against a transaction-level model built from cycle stamps.
module tb_nodf_module_status_tracker;
    import nodf_mon_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    nodf_module_status_tracker_if #(.CNT_W(DEF_CNT_W)) bus();

    nodf_module_status_tracker #(.CNT_W(DEF_CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Model: 0 idle, 1 open transaction, 2 finished; latency from start/done cycle stamps
    int          m_state;
    longint      cyc, start_cyc;
    bit          m_rs, m_svld, m_dreq, m_inc, m_esd, m_esp;
    logic [31:0] m_txn, m_last, m_min, m_max, m_act, m_stall;

    function automatic void model_reset();
        m_state = 0; cyc = 0; start_cyc = 0; m_rs = 0;
        m_svld = 0; m_dreq = 0; m_inc = 0; m_esd = 0; m_esp = 0;
        m_txn = 0; m_last = 0; m_min = 32'hFFFF_FFFF; m_max = 0; m_act = 0; m_stall = 0;
    endfunction

    function automatic void record(longint lat);
        m_txn  = m_txn + 1;
        m_last = 32'(lat);
        if (m_last < m_min) m_min = m_last;
        if (m_last > m_max) m_max = m_last;
        m_svld = 1;
    endfunction

    function automatic void model_step(bit s, bit r, bit d, bit c, bit f);
        bit de;
        de = d & c;
        m_svld = 0;
        m_dreq = 0;
        if (m_state != 2) begin
            if (m_state == 0) begin
                if (d && !s) m_esd = 1;
                if (s && de) record(1);
                else if (s) begin m_state = 1; start_cyc = cyc; m_rs = r; end
            end else begin
                m_act = m_act + 1;
                if (d && !c) m_stall = m_stall + 1;
                if (!s && !m_rs && !r) m_esp = 1;
                if (r) m_rs = 1;
                if (de) begin
                    record(cyc - start_cyc + 1);
                    if (s) begin start_cyc = cyc; m_rs = r; end
                    else m_state = 0;
                end
            end
            if (f) begin
                if (m_state == 1) m_inc = 1;
                m_state = 2;
                m_dreq = 1;
            end
        end
        cyc++;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mon_state",     32'(bus.mon_state),         32'(m_state));
        chk("txn_count",     bus.txn_count,              m_txn);
        chk("last_latency",  bus.last_latency,           m_last);
        chk("min_latency",   bus.min_latency,            m_min);
        chk("max_latency",   bus.max_latency,            m_max);
        chk("active_cycles", bus.active_cycles,          m_act);
        chk("sample_vld",    32'(bus.sample_vld),        32'(m_svld));
        chk("dump_req",      32'(bus.dump_req),          32'(m_dreq));
        chk("incomplete",    32'(bus.incomplete),        32'(m_inc));
        chk("err_spurious",  32'(bus.err_spurious_done), 32'(m_esd));
        chk("err_start_drop",32'(bus.err_start_drop),    32'(m_esp));
`ifdef NODF_MON_STALL_CNT_EN
        chk("stall_cycles",  bus.stall_cycles,           m_stall);
`endif
    endtask

    task automatic step(input bit s, input bit r, input bit d, input bit c, input bit f);
        bus.ap_start = s; bus.ap_ready = r; bus.ap_done = d; bus.ap_continue = c; bus.finish = f;
        @(posedge clock);
        model_step(s, r, d, c, f);
        #1;
        check_all();
    endtask

    // finish is held high through the reset edge: reset must win
    task automatic do_reset();
        reset = 1'b1;
        bus.ap_start = 0; bus.ap_ready = 0; bus.ap_done = 0; bus.ap_continue = 1; bus.finish = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        chk("min_reset_const", bus.min_latency, MIN_LAT_RST);
        bus.finish = 0;
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clock);
        #1;
        do_reset();

        // single transaction, latency 5
        step(0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("single_last", bus.last_latency, 32'd5);
        chk("single_vld",  32'(bus.sample_vld), 32'd1);
        chk("single_txn",  bus.txn_count, 32'd1);
        step(0, 0, 0, 1, 0);
        chk("single_vld_drop", 32'(bus.sample_vld), 32'd0);

        // back-to-back: latency 3 then 7 with no idle gap
        do_reset();
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        chk("b2b_no_gap", 32'(bus.mon_state), 32'd1);
        repeat (5) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("b2b_txn", bus.txn_count, 32'd2);
        chk("b2b_min", bus.min_latency, 32'd3);
        chk("b2b_max", bus.max_latency, 32'd7);

        // start and done together from idle
        do_reset();
        step(1, 0, 1, 1, 0);
        chk("comb_state", 32'(bus.mon_state), 32'd0);
        chk("comb_lat",   bus.last_latency, 32'd1);

        // sticky error flags
        do_reset();
        step(0, 0, 1, 1, 0);
        chk("spurious_set", 32'(bus.err_spurious_done), 32'd1);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("start_drop_set", 32'(bus.err_start_drop), 32'd1);
        repeat (3) step(0, 0, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        chk("spurious_sticky",   32'(bus.err_spurious_done), 32'd1);
        chk("start_drop_sticky", 32'(bus.err_start_drop), 32'd1);

`ifdef NODF_MON_STALL_CNT_EN
        do_reset();
        step(1, 1, 0, 1, 0);
        repeat (4) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("stall_count", bus.stall_cycles, 32'd4);
        chk("stall_lat",   bus.last_latency, 32'd6);
`endif

        // done in the finish cycle still counts
        do_reset();
        step(1, 1, 0, 1, 0);
        step(0, 0, 1, 1, 1);
        chk("fin_done_txn", bus.txn_count, 32'd1);
        chk("fin_dump",     32'(bus.dump_req), 32'd1);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
                 ($urandom % 4) != 0, 1'b0);
        end

        // finish with a transaction open, then toggle everything while frozen
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 1);
        chk("fin_state",      32'(bus.mon_state), 32'd2);
        chk("fin_dump_pulse", 32'(bus.dump_req), 32'd1);
        chk("fin_incomplete", 32'(bus.incomplete), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step($urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2);
        end
        chk("fin_dump_once", 32'(bus.dump_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
